// File: rtl/sm_pkt_merge_arb_pkg.sv
// Shared definitions for the packet merge stage: default field widths, arbitration modes
// and small index helpers used by the merger and its neighbours.
package sm_pkt_merge_arb_pkg;

    localparam int NODE_W_DEF = 16;
    localparam int GEN_W_DEF  = 12;
    localparam int OPR_W_DEF  = 32;
    localparam int WEN_W_DEF  = 2;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Packet layout is {node, gen, opr0, opr1, mem_wen}; mem_wen sits at bit 0.
    function automatic int pkt_width(input int node_w, input int gen_w,
                                     input int opr_w, input int wen_w);
        return node_w + gen_w + 2 * opr_w + wen_w;
    endfunction

    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sm_pkt_fifo.sv
// Synchronous FIFO with full/empty flags and a registered occupancy count.
// A push on a full FIFO is ignored even if the same cycle pops.
module sm_pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clka,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clka) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_pkt_merge_arb.sv
// N-way packet merger: one FIFO per input channel, drained by a round-robin or
// fixed-priority arbiter into a single registered valid/ready output.
module sm_pkt_merge_arb
    import sm_pkt_merge_arb_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int DEPTH    = 4,
    parameter int NODE_W   = NODE_W_DEF,
    parameter int GEN_W    = GEN_W_DEF,
    parameter int OPR_W    = OPR_W_DEF,
    parameter int WEN_W    = WEN_W_DEF,
    parameter int ARB_MODE = ARB_RR,
    localparam int PKT_W   = pkt_width(NODE_W, GEN_W, OPR_W, WEN_W),
    localparam int SRC_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_vld,
    output logic [N_IN-1:0]       in_rdy,
    input  logic [N_IN*PKT_W-1:0] in_pkt,
    output logic [NODE_W-1:0]     node_o,
    output logic [GEN_W-1:0]      gen_o,
    output logic [OPR_W-1:0]      opr0_o,
    output logic [OPR_W-1:0]      opr1_o,
    output logic [WEN_W-1:0]      mem_wen_o,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [SRC_W-1:0]      out_src
);

    localparam int WEN_LSB  = 0;
    localparam int OPR1_LSB = WEN_LSB + WEN_W;
    localparam int OPR0_LSB = OPR1_LSB + OPR_W;
    localparam int GEN_LSB  = OPR0_LSB + OPR_W;
    localparam int NODE_LSB = GEN_LSB + GEN_W;

    logic [N_IN-1:0]  fifo_full;
    logic [N_IN-1:0]  fifo_empty;
    logic [N_IN-1:0]  fifo_pop;
    logic [N_IN-1:0]  req;
    logic [PKT_W-1:0] fifo_head [N_IN];
    logic [PKT_W-1:0] out_pkt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant;
    logic             grant_vld;
    logic             load;

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        logic [$clog2(DEPTH):0] count;
        logic                   unused_count;

        sm_pkt_fifo #(
            .DEPTH (DEPTH),
            .W     (PKT_W)
        ) u_fifo (
            .clka  (clka),
            .rst   (rst),
            .push  (in_vld[i]),
            .pop   (fifo_pop[i]),
            .din   (in_pkt[i*PKT_W +: PKT_W]),
            .dout  (fifo_head[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .count (count)
        );

        assign unused_count = ^count;
        assign fifo_pop[i]  = load & grant_vld & (grant == SRC_W'(i));
    end

    assign in_rdy = ~fifo_full;
    assign req    = ~fifo_empty;
    assign load   = ~out_vld | out_rdy;

    // Rotate the request vector to start at the pointer, then take the first hit.
    always_comb begin
        int               start;
        int               idx;
        logic [SRC_W-1:0] sel;
        grant     = '0;
        grant_vld = 1'b0;
        start     = (ARB_MODE == ARB_FIXED) ? 0 : int'(rr_ptr);
        for (int k = 0; k < N_IN; k++) begin
            idx = start + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            sel = SRC_W'(idx);
            if (!grant_vld && req[sel]) begin
                grant     = sel;
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_pkt <= '0;
            out_src <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            if (grant_vld) begin
                out_vld <= 1'b1;
                out_pkt <= fifo_head[grant];
                out_src <= grant;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr <= SRC_W'(wrap_next(int'(grant), N_IN));
                end
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    assign node_o    = out_pkt[NODE_LSB +: NODE_W];
    assign gen_o     = out_pkt[GEN_LSB  +: GEN_W];
    assign opr0_o    = out_pkt[OPR0_LSB +: OPR_W];
    assign opr1_o    = out_pkt[OPR1_LSB +: OPR_W];
    assign mem_wen_o = out_pkt[WEN_LSB  +: WEN_W];

endmodule

// File: tb/tb_sm_pkt_merge_arb.sv
// Scoreboard bench for sm_pkt_merge_arb: a round-robin instance (d=0) and a fixed-priority
// instance (d=1), each with per-channel expected-packet queues.
module tb_sm_pkt_merge_arb;

    localparam int N     = 3;
    localparam int D     = 4;
    localparam int PKT_W = 16 + 12 + 2 * 32 + 2;

    logic              clka = 1'b0;
    logic              rst;
    logic              out_rdy;
    logic [N-1:0]      in_vld  [2];
    logic [N-1:0]      in_rdy  [2];
    logic [N*PKT_W-1:0] in_pkt [2];
    logic [15:0]       node_o  [2];
    logic [11:0]       gen_o   [2];
    logic [31:0]       opr0_o  [2];
    logic [31:0]       opr1_o  [2];
    logic [1:0]        wen_o   [2];
    logic              out_vld [2];
    logic [1:0]        out_src [2];
    logic [PKT_W-1:0]  out_pkt [2];

    logic [PKT_W-1:0]  sb [2][N][$];
    int                src_log [2][$];
    bit                hold [2];
    logic [PKT_W-1:0]  prev_pkt [2];
    logic [1:0]        prev_src [2];
    int                acc [N];
    logic [15:0]       next_node = 16'd1;
    int                errors = 0;
    int                checks = 0;

    always #5 clka = ~clka;

    sm_pkt_merge_arb #(.N_IN(N), .DEPTH(D), .ARB_MODE(0)) u_rr (
        .clka(clka), .rst(rst), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .in_pkt(in_pkt[0]),
        .node_o(node_o[0]), .gen_o(gen_o[0]), .opr0_o(opr0_o[0]), .opr1_o(opr1_o[0]),
        .mem_wen_o(wen_o[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy), .out_src(out_src[0])
    );

    sm_pkt_merge_arb #(.N_IN(N), .DEPTH(D), .ARB_MODE(1)) u_fp (
        .clka(clka), .rst(rst), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .in_pkt(in_pkt[1]),
        .node_o(node_o[1]), .gen_o(gen_o[1]), .opr0_o(opr0_o[1]), .opr1_o(opr1_o[1]),
        .mem_wen_o(wen_o[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy), .out_src(out_src[1])
    );

    assign out_pkt[0] = {node_o[0], gen_o[0], opr0_o[0], opr1_o[0], wen_o[0]};
    assign out_pkt[1] = {node_o[1], gen_o[1], opr0_o[1], opr1_o[1], wen_o[1]};

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [PKT_W-1:0] make_pkt(input int ch);
        logic [PKT_W-1:0] p;
        p = {next_node, 12'(ch), $urandom(), $urandom(), next_node[1:0]};
        next_node = next_node + 16'd1;
        return p;
    endfunction

    function automatic int pending();
        int n = int'(out_vld[0]) + int'(out_vld[1]);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                n += sb[d][i].size();
        return n;
    endfunction

    // Record accepted pushes, check held outputs and score consumed packets, then advance one cycle.
    task automatic tick();
        logic [PKT_W-1:0] exp_pkt;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                hold[d] = 1'b0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (in_vld[d][i] && in_rdy[d][i]) begin
                    sb[d][i].push_back(in_pkt[d][i*PKT_W +: PKT_W]);
                    if (d == 0) acc[i]++;
                end
            end
            if (hold[d]) begin
                checkOutput($sformatf("hold%0d_pkt", d), out_pkt[d], prev_pkt[d]);
                checkOutput($sformatf("hold%0d_src", d), out_src[d], prev_src[d]);
                checkOutput($sformatf("hold%0d_vld", d), out_vld[d], 1);
            end
            if (out_vld[d] && out_rdy) begin
                if (int'(out_src[d]) >= N || sb[d][out_src[d]].size() == 0) begin
                    checkOutput($sformatf("unexpected%0d", d), out_vld[d], 0);
                end else begin
                    exp_pkt = sb[d][out_src[d]].pop_front();
                    checkOutput($sformatf("pkt%0d_ch%0d", d, out_src[d]), out_pkt[d], exp_pkt);
                    src_log[d].push_back(int'(out_src[d]));
                end
            end
            hold[d]     = out_vld[d] && !out_rdy;
            prev_pkt[d] = out_pkt[d];
            prev_src[d] = out_src[d];
        end
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic applyStimulus(input logic [N-1:0] v_rr, input logic [N-1:0] v_fp,
                                 input logic rdy);
        for (int i = 0; i < N; i++) begin
            in_pkt[0][i*PKT_W +: PKT_W] = make_pkt(i);
            in_pkt[1][i*PKT_W +: PKT_W] = make_pkt(i);
        end
        in_vld[0] = v_rr;
        in_vld[1] = v_fp;
        out_rdy   = rdy;
        tick();
    endtask

    task automatic applyReset(input int cycles, input logic [N-1:0] vld);
        rst       = 1'b1;
        in_vld[0] = vld;
        in_vld[1] = vld;
        repeat (cycles) tick();
        rst       = 1'b0;
        in_vld[0] = '0;
        in_vld[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                sb[d][i].delete();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 60; c++) begin
            if (pending() == 0) break;
            applyStimulus('0, '0, 1'b1);
        end
        checkOutput(tag, pending(), 0);
    endtask

    initial begin
        int exp_rr [6] = '{0, 1, 2, 0, 1, 2};
        int exp_fp [6] = '{0, 0, 0, 1, 1, 2};
        logic [PKT_W-1:0] t2_pkt;

        rst       = 1'b1;
        out_rdy   = 1'b1;
        in_vld[0] = '0;
        in_vld[1] = '0;
        in_pkt[0] = '0;
        in_pkt[1] = '0;
        @(negedge clka);

        // Reset with all channels presenting valid data.
        applyReset(2, '1);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("t1_vld%0d", d), out_vld[d], 0);
            checkOutput($sformatf("t1_pkt%0d", d), out_pkt[d], 0);
            checkOutput($sformatf("t1_src%0d", d), out_src[d], 0);
            checkOutput($sformatf("t1_rdy%0d", d), in_rdy[d], 3'b111);
        end
        repeat (3) applyStimulus('0, '0, 1'b1);
        checkOutput("t1_no_pkt_vld", out_vld[0], 0);
        checkOutput("t1_no_pkt_log", src_log[0].size(), 0);

        // Single packet on channel 1, one-cycle latency.
        t2_pkt = {16'h0012, 12'h034, 32'hDEADBEEF, 32'h01234567, 2'b01};
        in_pkt[0][1*PKT_W +: PKT_W] = t2_pkt;
        in_vld[0] = 3'b010;
        out_rdy   = 1'b1;
        tick();
        checkOutput("t2_not_yet", out_vld[0], 0);
        in_vld[0] = '0;
        tick();
        checkOutput("t2_vld", out_vld[0], 1);
        checkOutput("t2_src", out_src[0], 1);
        checkOutput("t2_pkt", out_pkt[0], t2_pkt);
        drain("t2_drain");

        // Continuous feed: round-robin rotates, fixed priority sticks to channel 0.
        applyReset(1, '0);
        src_log[0].delete();
        src_log[1].delete();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(3'b111, (c == 0) ? 3'b111 : (c == 1) ? 3'b011 : (c == 2) ? 3'b001 : 3'b000, 1'b1);
        end
        drain("t3_drain");
        checkOutput("t3_rr_len", src_log[0].size() >= 6, 1);
        checkOutput("t3_fp_len", src_log[1].size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < src_log[0].size()) checkOutput($sformatf("t3_rr_src%0d", k), src_log[0][k], exp_rr[k]);
            if (k < src_log[1].size()) checkOutput($sformatf("t3_fp_src%0d", k), src_log[1][k], exp_fp[k]);
        end

        // Back-pressure: 4 in the FIFO plus 1 in the output register, then the 6th is refused.
        acc[0] = 0;
        repeat (6) applyStimulus(3'b001, '0, 1'b0);
        checkOutput("t4_accepted", acc[0], 5);
        checkOutput("t4_rdy0", in_rdy[0][0], 0);
        checkOutput("t4_head", out_pkt[0], sb[0][0][0]);
        repeat (2) applyStimulus('0, '0, 1'b0);
        drain("t4_drain");

        // Push and pop on the same cycle at count 2: the remaining room must still be exactly 2.
        acc[0] = 0;
        repeat (3) applyStimulus(3'b001, '0, 1'b0);
        applyStimulus(3'b001, '0, 1'b1);
        repeat (3) applyStimulus(3'b001, '0, 1'b0);
        checkOutput("t5_accepted", acc[0], 6);
        checkOutput("t5_rdy0", in_rdy[0][0], 0);
        drain("t5_drain");

        // Reset while a packet is held and FIFOs are partly full; the pointer must restart at 0.
        repeat (2) applyStimulus(3'b111, '0, 1'b0);
        checkOutput("t6_pre_vld", out_vld[0], 1);
        applyReset(1, '0);
        checkOutput("t6_vld", out_vld[0], 0);
        checkOutput("t6_rdy", in_rdy[0], 3'b111);
        src_log[0].delete();
        applyStimulus(3'b110, '0, 1'b1);
        drain("t6_drain");
        checkOutput("t6_len", src_log[0].size(), 2);
        if (src_log[0].size() >= 2) begin
            checkOutput("t6_src0", src_log[0][0], 1);
            checkOutput("t6_src1", src_log[0][1], 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
